input_conditioner: RTL and testbench

- Sits directly downstream of the input synchronizer in the traffic light system.
- Consumes the already-synchronized sensor, walk-request and reprogram levels.
- Debounces each input with a per-channel stability counter.
- Produces clean outputs for the traffic light controller FSM: a debounced sensor level, one-cycle rising-edge pulses, and a sticky walk-request flag cleared by an acknowledge handshake from the FSM.

---
 rtl/input_conditioner_if.sv | 49 ++++
 rtl/input_conditioner.sv | 147 ++++++++++++++
 tb/tb_input_conditioner.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/input_conditioner_if.sv
// -----------------------------------------------------------------------------
// input_conditioner_if
//   Bundles the signals between the input conditioner and the blocks around
//   it. The synchronized levels and walk_ack go into the conditioner. The
//   clean levels, pulses and the walk flag come out of it.
//
//   Modports:
//     master : surrounding logic (synchronizer / controller FSM side)
//     slave  : the input conditioner itself
//
//   Signals:
//     sensor_sync, wr_sync, prog_sync  synchronized raw levels
//     walk_ack                         FSM acknowledge for walk_pending
//     sensor_level, prog_level         debounced levels
//     sensor_rise, prog_pulse          one-cycle debounced rising-edge pulses
//     walk_pending                     sticky walk request
//     walk_count                       saturating walk count, present only
//                                      when WALK_COUNT_EN is defined
// -----------------------------------------------------------------------------
interface input_conditioner_if;
   logic       sensor_sync;
   logic       wr_sync;
   logic       prog_sync;
   logic       walk_ack;
   logic       sensor_level;
   logic       sensor_rise;
   logic       walk_pending;
   logic       prog_pulse;
   logic       prog_level;
`ifdef WALK_COUNT_EN
   logic [7:0] walk_count;
`endif

   modport master (
      output sensor_sync, wr_sync, prog_sync, walk_ack,
      input  sensor_level, sensor_rise, walk_pending, prog_pulse, prog_level
`ifdef WALK_COUNT_EN
      , input walk_count
`endif
   );

   modport slave (
      input  sensor_sync, wr_sync, prog_sync, walk_ack,
      output sensor_level, sensor_rise, walk_pending, prog_pulse, prog_level
`ifdef WALK_COUNT_EN
      , output walk_count
`endif
   );
endinterface

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//   Debounces the synchronized sensor, walk-request and reprogram levels for
//   the traffic light controller. Each channel has its own stability counter.
//   From the debounced levels the block builds registered rising-edge pulses
//   and a sticky walk-request flag. The FSM clears that flag with walk_ack.
//
//   Optional feature macro: WALK_COUNT_EN. When it is defined, the block adds
//   walk_count, an 8-bit saturating count of walk-request set events.
//
//   Parameters:
//     DEBOUNCE_CYCLES  consecutive differing samples needed to flip a level
//     CNT_W            debounce counter width (2^CNT_W > DEBOUNCE_CYCLES)
//
//   Ports:
//     clock    system clock, posedge
//     reset    synchronous, active-high
//     cond_if  input_conditioner_if.slave (levels in, clean signals out)
// -----------------------------------------------------------------------------

// Per-channel debouncer. level_o is the registered debounced level.
// rise_evt_o is combinational. It is high in the cycle whose closing edge
// moves the level 0->1, so the parent can register pulses on that same edge.
module ic_debounce #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic in_i,
   output logic level_o,
   output logic rise_evt_o
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q + CNT_W'(1);
      if (in_i == deb_q) begin
         cnt_d = '0;                 // any agreeing sample restarts the window
      end else if (cnt_q == LAST) begin
         deb_d = in_i;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         deb_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end

   assign level_o    = deb_q;
   assign rise_evt_o = deb_d & ~deb_q;
endmodule

module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input_conditioner_if.slave   cond_if
);
   // Lane map: 0 = sensor, 1 = walk request, 2 = reprogram
   localparam int NUM_LANES = 3;
   localparam int L_SENS    = 0;
   localparam int L_WR      = 1;
   localparam int L_PROG    = 2;

   logic [NUM_LANES-1:0] raw, lvl, rise_evt;

   assign raw = {cond_if.prog_sync, cond_if.wr_sync, cond_if.sensor_sync};

   genvar g;
   generate
      for (g = 0; g < NUM_LANES; g++) begin : g_lane
         ic_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
         ) u_deb (
            .clock      (clock),
            .reset      (reset),
            .in_i       (raw[g]),
            .level_o    (lvl[g]),
            .rise_evt_o (rise_evt[g])
         );
      end
   endgenerate

   // The walk level is consumed only through its rise event.
   logic unused_wr_lvl;
   assign unused_wr_lvl = lvl[L_WR];

   logic sens_rise_q, prog_pulse_q, walk_q;
   logic sens_rise_d, prog_pulse_d, walk_d;

   always_comb begin
      sens_rise_d  = rise_evt[L_SENS];
      prog_pulse_d = rise_evt[L_PROG];
      // A set wins over a same-edge ack, so a fresh request is never dropped.
      walk_d       = rise_evt[L_WR] | (walk_q & ~cond_if.walk_ack);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sens_rise_q  <= 1'b0;
         prog_pulse_q <= 1'b0;
         walk_q       <= 1'b0;
      end else begin
         sens_rise_q  <= sens_rise_d;
         prog_pulse_q <= prog_pulse_d;
         walk_q       <= walk_d;
      end
   end

   assign cond_if.sensor_level = lvl[L_SENS];
   assign cond_if.prog_level   = lvl[L_PROG];
   assign cond_if.sensor_rise  = sens_rise_q;
   assign cond_if.prog_pulse   = prog_pulse_q;
   assign cond_if.walk_pending = walk_q;

`ifdef WALK_COUNT_EN
   // Counts every set event, even while walk_pending is already high.
   // walk_ack does not clear it.
   logic [7:0] wcnt_q, wcnt_d;

   always_comb begin
      wcnt_d = wcnt_q;
      if (rise_evt[L_WR] && (wcnt_q != 8'hFF)) wcnt_d = wcnt_q + 8'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) wcnt_q <= 8'd0;
      else       wcnt_q <= wcnt_d;
   end

   assign cond_if.walk_count = wcnt_q;
`endif
endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES = 4.
// Each step drives the inputs for one clock. After the edge it pushes the
// hand-computed output vector {sensor_level, sensor_rise, walk_pending,
// prog_pulse, prog_level}. A monitor pops and compares on every falling edge.
module tb_input_conditioner;
   localparam int D = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;

   input_conditioner_if ifc();

   input_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (16)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .cond_if (ifc.slave)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0] v;
      int         wc;   // -1: walk_count not checked
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   bit   done  = 1'b0;
   bit   final_chk = 1'b0;

   function automatic logic [4:0] obs();
      return {ifc.sensor_level, ifc.sensor_rise, ifc.walk_pending,
              ifc.prog_pulse, ifc.prog_level};
   endfunction

   function automatic int sat(input int x);
      return (x > 255) ? 255 : x;
   endfunction

   // Monitor: compares the oldest expectation against the DUT
   always @(negedge clock) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         tests++;
         if (obs() !== e.v) begin
            fails++;
            $display("FAIL %s: got %b want %b (t=%0t)", e.tag, obs(), e.v, $time);
         end
`ifdef WALK_COUNT_EN
         if (e.wc >= 0) begin
            tests++;
            if (ifc.walk_count !== 8'(e.wc)) begin
               fails++;
               $display("FAIL %s_wc: got %0d want %0d", e.tag, ifc.walk_count, e.wc);
            end
         end
`endif
      end else if (done && !final_chk) begin
         final_chk = 1'b1;
         tests++;
         if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d left want 0", sb.size());
         end
      end
   end

   task automatic step(input logic s, input logic w, input logic p, input logic a,
                       input logic [4:0] v, input string tag, input int wc = -1);
      ifc.sensor_sync = s;
      ifc.wr_sync     = w;
      ifc.prog_sync   = p;
      ifc.walk_ack    = a;
      @(posedge clock);
      sb.push_back('{v: v, wc: wc, tag: tag});
      #1;
   endtask

   initial begin
      ifc.sensor_sync = 1'b0;
      ifc.wr_sync     = 1'b0;
      ifc.prog_sync   = 1'b0;
      ifc.walk_ack    = 1'b0;

      // Reset with all inputs high, then release
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 5'b00000, "rst_hold");
      reset = 1'b0;
      for (int i = 0; i < D - 1; i++) step(1, 1, 1, 0, 5'b00000, "rst_rel");
      step(1, 1, 1, 0, 5'b11111, "rise_all");
      step(1, 1, 1, 0, 5'b10101, "pulse_end");
      step(1, 1, 1, 1, 5'b10001, "ack1");
      for (int i = 0; i < D - 1; i++) step(0, 0, 0, 0, 5'b10001, "fall_wait");
      step(0, 0, 0, 0, 5'b00000, "fall");
      step(0, 0, 0, 0, 5'b00000, "fall_nopulse");

      // Glitch rejection, then a real press
      for (int i = 0; i < D - 1; i++) step(1, 0, 0, 0, 5'b00000, "glitch");
      step(0, 0, 0, 0, 5'b00000, "glitch_end");
      for (int i = 0; i < D - 1; i++) step(1, 0, 0, 0, 5'b00000, "sens_wait");
      step(1, 0, 0, 0, 5'b11000, "sens_rise");
      step(1, 0, 0, 0, 5'b10000, "sens_hold");

      // Walk handshake with a held button
      for (int i = 0; i < D - 1; i++) step(1, 1, 0, 0, 5'b10000, "wr_wait");
      step(1, 1, 0, 0, 5'b10100, "wr_set");
      for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 5'b10100, "wr_held");
      step(1, 1, 0, 1, 5'b10000, "wr_ack");
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 5'b10000, "wr_cleared");
      step(1, 1, 0, 1, 5'b10000, "ack_idle");

      // Set and ack on the same edge
      for (int i = 0; i < D; i++) step(1, 0, 0, 0, 5'b10000, "wr_rel");
      for (int i = 0; i < D; i++)
         step(1, 1, 0, 0, (i == D - 1) ? 5'b10100 : 5'b10000, "wr_press");
      for (int i = 0; i < D; i++) step(1, 0, 0, 0, 5'b10100, "wr_rel2");
      for (int i = 0; i < D - 1; i++) step(1, 1, 0, 0, 5'b10100, "wr_press2");
      step(1, 1, 0, 1, 5'b10100, "set_ack_same");
      step(1, 1, 0, 0, 5'b10100, "set_won");
      step(1, 1, 0, 1, 5'b10000, "ack2");

      // Reset in the middle of a prog debounce
      step(1, 1, 1, 0, 5'b10000, "prog_part");
      step(1, 1, 1, 0, 5'b10000, "prog_part");
      reset = 1'b1;
      step(1, 1, 1, 0, 5'b00000, "mid_rst");
      reset = 1'b0;
      for (int i = 0; i < D - 1; i++) step(1, 1, 1, 0, 5'b00000, "post_rst");
      step(1, 1, 1, 0, 5'b11111, "post_rise");
      step(1, 1, 1, 0, 5'b10101, "post_hold");

`ifdef WALK_COUNT_EN
      // Saturating walk count over 300 press/release cycles
      reset = 1'b1;
      step(0, 0, 0, 0, 5'b00000, "wc_rst", 0);
      reset = 1'b0;
      for (int i = 0; i < 300; i++) begin
         for (int j = 0; j < D; j++)
            step(0, 1, 0, 0, (i > 0 || j == D - 1) ? 5'b00100 : 5'b00000, "wc_press",
                 (j == D - 1) ? sat(i + 1) : sat(i));
         for (int j = 0; j < D; j++)
            step(0, 0, 0, 0, 5'b00100, "wc_rel", sat(i + 1));
      end
      step(0, 0, 0, 1, 5'b00000, "wc_ack", 255);
      step(0, 0, 0, 0, 5'b00000, "wc_hold", 255);
`endif

      done = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
